// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer
//   SD-bus CMD line engine running on the divided SD clock. It captures a
//   command index/argument, frames it as a 48-bit command with CRC7, shifts
//   it out MSB first on CMD, then holds the line idle for the Ncc gap.
//
//   Optional response receiver: define SD_CMD_RSP_EN to add the WAIT_RSP/RX
//   states, which capture a 48-bit response from CMD_IN. Without the macro,
//   CMD_IN is ignored and the RSP_* outputs are tied low.
//
// Ports
//   CLK          SD clock; all logic on posedge
//   RST          asynchronous, active-high reset
//   START        request pulse; sampled only while BUSY=0
//   CMD_IDX      6-bit command index, captured on accepted START
//   CMD_ARG      32-bit command argument, captured on accepted START
//   BUSY         high from the cycle after accepted START through DONE
//   DONE         single-cycle completion pulse
//   CMD_OUT      serial command bit to the pad
//   CMD_OE       pad output enable
//   CMD_IN       pad input (response receiver only)
//   RSP_DATA     received response bits 47..8 (response receiver only)
//   RSP_CRC_ERR  response CRC/framing error (response receiver only)
//   RSP_TOUT     response start-bit timeout (response receiver only)
module sd_cmd_serializer #(
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [5:0]  CMD_IDX,
  input  logic [31:0] CMD_ARG,
  output logic        BUSY,
  output logic        DONE,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  input  logic        CMD_IN,
  output logic [39:0] RSP_DATA,
  output logic        RSP_CRC_ERR,
  output logic        RSP_TOUT
);

  localparam int unsigned FRAME_W   = 48;
  localparam int unsigned PAYLOAD_W = 40;
  localparam int unsigned CRC_W     = 7;
  localparam int unsigned BIT_CNT_W = 6;
  localparam int unsigned GAP_CNT_W = 8;

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES);

`ifdef SD_CMD_RSP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_WAIT_RSP, S_RX, S_GAP, S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_GAP, S_FIN
  } state_t;
`endif

  // Serial CRC7 (x^7 + x^3 + 1, init 0) evaluated over a whole payload.
  function automatic logic [CRC_W-1:0] crc7(input logic [PAYLOAD_W-1:0] payload);
    logic [PAYLOAD_W-1:0] d;
    logic [CRC_W-1:0]     c;
    logic                 fb;
    d = payload;
    c = '0;
    for (int unsigned i = 0; i < PAYLOAD_W; i++) begin
      fb = d[PAYLOAD_W-1] ^ c[CRC_W-1];
      d  = {d[PAYLOAD_W-2:0], 1'b0};
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  state_t                 state;
  logic [FRAME_W-1:0]     frame;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;

  // Frame built from the live inputs; only latched on an accepted START.
  logic [PAYLOAD_W-1:0]   payload_c;
  logic [FRAME_W-1:0]     frame_c;

  assign payload_c = {2'b01, CMD_IDX, CMD_ARG};
  assign frame_c   = {payload_c, crc7(payload_c), 1'b1};

`ifdef SD_CMD_RSP_EN
  localparam int unsigned RX_SR_W = FRAME_W - 1;
  localparam logic [GAP_CNT_W-1:0] TOUT_LAST = GAP_CNT_W'(RSP_TIMEOUT - 1);

  logic [GAP_CNT_W-1:0]   wait_cnt;
  logic [BIT_CNT_W-1:0]   rx_cnt;
  logic [RX_SR_W-1:0]     rx_sr;

  // Complete response as seen at the edge that samples its last bit.
  logic [FRAME_W-1:0]     rx_frame_c;
  logic                   rsp_bad_c;

  assign rx_frame_c = {rx_sr, CMD_IN};
  assign rsp_bad_c  = rx_frame_c[46] | ~rx_frame_c[0] |
                      (crc7(rx_frame_c[47:8]) != rx_frame_c[7:1]);
`endif

  // Command engine: state, counters and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      CMD_OUT  <= 1'b1;
      CMD_OE   <= 1'b0;
`ifdef SD_CMD_RSP_EN
      wait_cnt    <= '0;
      rx_cnt      <= '0;
      rx_sr       <= '0;
      RSP_DATA    <= '0;
      RSP_CRC_ERR <= 1'b0;
      RSP_TOUT    <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state   <= S_TX;
            frame   <= frame_c;
            bit_cnt <= BIT_CNT_W'(FRAME_W - 1);
            BUSY    <= 1'b1;
            CMD_OE  <= 1'b1;
            CMD_OUT <= frame_c[FRAME_W-1];
`ifdef SD_CMD_RSP_EN
            RSP_CRC_ERR <= 1'b0;
            RSP_TOUT    <= 1'b0;
`endif
          end
        end

        // bit_cnt holds the index of the bit currently on the pad.
        S_TX: begin
          if (bit_cnt == '0) begin
            CMD_OE  <= 1'b0;
            CMD_OUT <= 1'b1;
`ifdef SD_CMD_RSP_EN
            state    <= S_WAIT_RSP;
            wait_cnt <= '0;
`else
            state    <= S_GAP;
            gap_cnt  <= GAP_CNT_W'(1);
`endif
          end else begin
            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
            CMD_OUT <= frame[bit_cnt - BIT_CNT_W'(1)];
          end
        end

`ifdef SD_CMD_RSP_EN
        // Line released; look for the response start bit.
        S_WAIT_RSP: begin
          if (!CMD_IN) begin
            state  <= S_RX;
            rx_sr  <= {rx_sr[RX_SR_W-2:0], CMD_IN};
            rx_cnt <= BIT_CNT_W'(FRAME_W - 2);
          end else if (wait_cnt == TOUT_LAST) begin
            RSP_TOUT <= 1'b1;
            state    <= S_GAP;
            gap_cnt  <= GAP_CNT_W'(1);
          end else begin
            wait_cnt <= wait_cnt + GAP_CNT_W'(1);
          end
        end

        // rx_cnt counts the response bits still to be sampled after this one.
        S_RX: begin
          rx_sr <= {rx_sr[RX_SR_W-2:0], CMD_IN};
          if (rx_cnt == '0) begin
            RSP_DATA    <= rx_frame_c[FRAME_W-1:8];
            RSP_CRC_ERR <= rsp_bad_c;
            state       <= S_GAP;
            gap_cnt     <= GAP_CNT_W'(1);
          end else begin
            rx_cnt <= rx_cnt - BIT_CNT_W'(1);
          end
        end
`endif

        // gap_cnt numbers the Ncc cycle currently on the line (1-based).
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= S_FIN;
            DONE    <= 1'b1;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_CNT_W'(1);
          end
        end

        S_FIN: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SD_CMD_RSP_EN
  // Receiver absent: response outputs held low, pad input and timeout unused.
  logic unused_rsp;

  assign unused_rsp  = CMD_IN ^ (RSP_TIMEOUT == 0);
  assign RSP_DATA    = '0;
  assign RSP_CRC_ERR = 1'b0;
  assign RSP_TOUT    = 1'b0;
`endif

endmodule

// File: doc/sd_cmd_serializer.md
Name: sd_cmd_serializer

Overview:
- SD-bus command-line engine, clocked by the divided SD clock produced by the block's clock-divider sibling.
- Takes a command index and argument from the host controller.
- Frames them into a 48-bit SD command with CRC7, drives them serially on CMD, then enforces the Ncc idle gap.
- Counterpart of the clock source: consumes SD_CLK edges and produces the protocol bits that ride on them.

Parameters:
GAP_CYCLES, 8, idle CMD-high cycles after each transaction (Ncc); legal range 1..255
RSP_TIMEOUT, 64, max cycles to wait for response start bit (feature only); legal range 1..255

Ports:
CLK  in  1  SD clock (divided clock); all logic on posedge
RST  in  1  asynchronous, active-high reset
START  in  1  request pulse; sampled only when BUSY=0
CMD_IDX  in  6  command index; captured on accepted START
CMD_ARG  in  32  command argument; captured on accepted START
BUSY  out  1  high from cycle after accepted START until DONE cycle inclusive
DONE  out  1  single-cycle completion pulse
CMD_OUT  out  1  serial command bit to pad
CMD_OE  out  1  pad output enable
CMD_IN  in  1  pad input (feature only)
RSP_DATA  out  40  received bits 47..8 of response (feature only)
RSP_CRC_ERR  out  1  response CRC/framing error (feature only)
RSP_TOUT  out  1  response timeout (feature only)

Behaviour:
- Reset values (all outputs): BUSY=0, DONE=0, CMD_OUT=1, CMD_OE=0, RSP_DATA=0, RSP_CRC_ERR=0, RSP_TOUT=0; state IDLE; all counters 0.
- States: IDLE -> TX -> (WAIT_RSP -> RX, feature only) -> GAP -> FIN -> IDLE.
- IDLE:
  - On START=1, capture 48-bit frame {0, 1, CMD_IDX, CMD_ARG, CRC7, 1} and enter TX.
  - START while BUSY=1 is ignored; no queuing.
- TX, 48 cycles:
  - Cycle 1 after acceptance: BUSY=1, CMD_OE=1, CMD_OUT=frame bit 47 (start bit 0).
  - One bit per cycle, MSB first; bit 0 (end bit 1) is driven in cycle 48.
  - Bit counter is 6 bits, counting 47 down to 0; no wrap.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0, computed over frame bits 47..8.
  - Computed serially during TX or in parallel at capture; either way the value placed in bits 7..1 must be correct before bit 7 is driven.
- GAP:
  - CMD_OE=0, CMD_OUT=1 for exactly GAP_CYCLES cycles.
- FIN:
  - DONE=1 and BUSY=1 for one cycle, then IDLE with BUSY=0.
  - A new START is accepted in the cycle following FIN.
- Latency without feature: accepted START to DONE = 48 + GAP_CYCLES + 1 cycles.
- RST asserted mid-operation: immediately returns to reset values; the CMD pad is released (CMD_OE=0); no DONE is produced.
- Error flags: hold their value until the next accepted START, which clears them.
- RSP_DATA: holds its value until overwritten by the next received response.

Optional Feature:
- Macro SD_CMD_RSP_EN.
- Defined:
  - After TX, enter WAIT_RSP with CMD_OE=0; sample CMD_IN each cycle.
  - CMD_IN=0 within RSP_TIMEOUT cycles is the start bit; enter RX and shift 47 further bits.
  - Set RSP_CRC_ERR if any of the following holds:
    - transmission bit != 0;
    - end bit != 1;
    - CRC7 over bits 47..8 != received bits 7..1.
  - RSP_DATA = received bits 47..8.
  - No start bit within RSP_TIMEOUT cycles: RSP_TOUT=1, RSP_DATA unchanged.
  - Both the RX path and the timeout path continue to GAP.
  - Only 48-bit responses are supported; R2 (136-bit) is not supported.
- Undefined: no WAIT_RSP/RX states; CMD_IN is ignored; RSP_DATA, RSP_CRC_ERR and RSP_TOUT are tied 0.

Test Plan:
- CMD0 (IDX=0, ARG=0) -> CMD_OUT serial frame 0x40_0000_0000_95; DONE exactly 57 cycles after START with GAP_CYCLES=8.
- CMD8 (IDX=8, ARG=0x000001AA) -> frame 0x48_0000_01AA_87; CMD17 (IDX=17, ARG=0) -> frame 0x51_0000_0000_55.
- START pulsed during TX and during GAP -> ignored; only one DONE; captured IDX/ARG unchanged; back-to-back START the cycle after FIN -> accepted.
- RST asserted at TX bit 20 -> next cycle CMD_OE=0, CMD_OUT=1, BUSY=0; no DONE; fresh CMD0 afterwards is correct.
- SD_CMD_RSP_EN: after the command, bench drives R1 response 0x08_0000_01AA_13 starting 5 cycles after the end bit -> RSP_DATA=0x08000001AA, RSP_CRC_ERR=0, RSP_TOUT=0; same response with one CRC bit flipped -> RSP_CRC_ERR=1.
- SD_CMD_RSP_EN: CMD_IN held 1 -> RSP_TOUT=1 after 64 cycles; DONE follows GAP_CYCLES+1 cycles later; the next START clears RSP_TOUT.
